// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame buffer slice.
package pixel_pkg;

  localparam int PIX_W         = 8;
  localparam int ID_W          = 8;
  localparam int PIX_PER_FRAME = 4;

  // One assembled 2x2 frame; px[0] sits in the least significant bits and
  // the sequence ID on top, which is also the layout used inside the FIFO.
  typedef struct packed {
    logic [ID_W-1:0]                      id;
    logic [PIX_PER_FRAME-1:0][PIX_W-1:0]  px;
  } frame_t;

  typedef enum logic {
    WAIT_R1 = 1'b0,
    WAIT_R2 = 1'b1
  } asm_state_t;

endpackage

// File: rtl/pixel_frame_fifo.sv
// Circular frame FIFO: one entry holds a whole frame, level counts entries.
module pixel_frame_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             doPush, doPop;

  assign full_o  = (level_q == LVL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign doPop   = pop_i & ~empty_o;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign doPush  = push_i & (~full_o | doPop);

  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = level_q;

  // Pointer and level next-state; depth is a power of two so pointers wrap naturally.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_W'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PTR_W'(1);
    case ({doPush, doPop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Control registers; the storage array below is left unreset on purpose.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // Frame storage write port.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/pixel_frame_buffer.sv
// Captures readout registers at read-phase ends, assembles 2x2 frames,
// queues them and streams them out one pixel per valid/ready beat.
module pixel_frame_buffer
  import pixel_pkg::*;
#(
  parameter int DATA_W     = PIX_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = ID_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          read1,
  input  logic                          read2,
  input  logic [DATA_W-1:0]             pix_in1,
  input  logic [DATA_W-1:0]             pix_in2,
  input  logic                          clear_flags,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [CNT_W-1:0]              out_frame_id,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          seq_error,
  output logic [CNT_W-1:0]              drop_count
);

  localparam int FRAME_W = PIX_PER_FRAME * DATA_W + CNT_W;
  localparam logic [1:0] LAST_IDX = 2'(PIX_PER_FRAME - 1);

  logic               read1_q, read2_q;
  logic               end1, end2;
  asm_state_t         state_q, state_d;
  logic [DATA_W-1:0]  px0_q, px1_q;
  logic [CNT_W-1:0]   id_q;
  logic               overflow_q, seqErr_q;
  logic [CNT_W-1:0]   dropCnt_q;
  logic [1:0]         idx_q;

  logic               capLow, pushReq, seqSet;
  logic               popFrame, pushOk, dropEvt;
  logic [FRAME_W-1:0] pushFrame, headFrame;
  logic               fifoFull, fifoEmpty;

  assign end1 = read1_q & ~read1;
  assign end2 = read2_q & ~read2;

  // Remember last cycle's strobes so a falling edge marks each phase end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      read1_q <= 1'b0;
      read2_q <= 1'b0;
    end else begin
      read1_q <= read1;
      read2_q <= read2;
    end
  end

  // Assembly FSM: decide capture, push and sequence-error events for this cycle.
  always_comb begin
    state_d = state_q;
    capLow  = 1'b0;
    pushReq = 1'b0;
    seqSet  = 1'b0;
    case (state_q)
      WAIT_R1: begin
        if (end1) begin
          capLow  = 1'b1;
          state_d = WAIT_R2;
        end else if (end2) begin
          seqSet = 1'b1;
        end
      end
      WAIT_R2: begin
        if (end1) begin
          capLow = 1'b1;
        end else if (end2) begin
          pushReq = 1'b1;
          state_d = WAIT_R1;
        end
      end
      default: state_d = WAIT_R1;
    endcase
    if (end1 && end2) seqSet = 1'b1;
  end

  // The second half of the frame goes straight from the bus into the FIFO.
  assign pushFrame = {id_q, pix_in2, pix_in1, px1_q, px0_q};
  assign popFrame  = out_valid & out_ready & (idx_q == LAST_IDX);
  assign pushOk    = pushReq & (~fifoFull | popFrame);
  assign dropEvt   = pushReq & ~pushOk;

  // FSM state, first-half pixels and the frame ID, which advances even on a drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WAIT_R1;
      px0_q   <= '0;
      px1_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (capLow) begin
        px0_q <= pix_in1;
        px1_q <= pix_in2;
      end
      if (pushReq) id_q <= id_q + CNT_W'(1);
    end
  end

  // Sticky flags and saturating drop counter; a new event beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      seqErr_q   <= 1'b0;
      dropCnt_q  <= '0;
    end else begin
      if (dropEvt)          overflow_q <= 1'b1;
      else if (clear_flags) overflow_q <= 1'b0;
      if (seqSet)           seqErr_q <= 1'b1;
      else if (clear_flags) seqErr_q <= 1'b0;
      if (dropEvt) begin
        if (dropCnt_q != '1) dropCnt_q <= dropCnt_q + CNT_W'(1);
      end else if (clear_flags) begin
        dropCnt_q <= '0;
      end
    end
  end

  pixel_frame_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushOk),
    .pop_i   (popFrame),
    .wdata_i (pushFrame),
    .rdata_o (headFrame),
    .level_o (fifo_level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // Pixel index within the head frame; wraps and pops on the last beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q <= '0;
    end else if (out_valid && out_ready) begin
      idx_q <= (idx_q == LAST_IDX) ? 2'd0 : idx_q + 2'd1;
    end
  end

  // Stream outputs; data and ID are zeroed while nothing is queued.
  always_comb begin
    out_valid    = ~fifoEmpty;
    out_data     = '0;
    out_frame_id = '0;
    out_last     = 1'b0;
    if (out_valid) begin
      out_data     = headFrame[idx_q*DATA_W +: DATA_W];
      out_frame_id = headFrame[PIX_PER_FRAME*DATA_W +: CNT_W];
      out_last     = (idx_q == LAST_IDX);
    end
  end

  assign overflow   = overflow_q;
  assign seq_error  = seqErr_q;
  assign drop_count = dropCnt_q;

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed bench for pixel_frame_buffer: frame assembly, streaming,
// backpressure, overflow, full-with-pop, sequence errors and async reset.
module tb_pixel_frame_buffer;
  import pixel_pkg::*;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 8;
  localparam int LVL_W      = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              read1, read2;
  logic [DATA_W-1:0] pix_in1, pix_in2;
  logic              clear_flags;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [CNT_W-1:0]  out_frame_id;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow, seq_error;
  logic [CNT_W-1:0]  drop_count;

  int total = 0;
  int bad   = 0;

  logic [7:0] beatData [$];
  logic       beatLast [$];
  logic [7:0] lastIds  [$];

  frame_t frames [6];

  bit         patReady [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] patData  [7] = '{8'h55, 8'h66, 8'h66, 8'h66, 8'h77, 8'h77, 8'h88};
  logic       patLast  [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  pixel_frame_buffer #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .read1        (read1),
    .read2        (read2),
    .pix_in1      (pix_in1),
    .pix_in2      (pix_in2),
    .clear_flags  (clear_flags),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_last     (out_last),
    .out_frame_id (out_frame_id),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .seq_error    (seq_error),
    .drop_count   (drop_count)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Record every beat that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      beatData.push_back(out_data);
      beatLast.push_back(out_last);
      if (out_last) lastIds.push_back(out_frame_id);
    end
  end

  // Hard stop in case something stalls the main sequence.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count one comparison and report it when observed and expected differ.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] beatAt(input int i);
    if (i < beatData.size()) return beatData[i];
    return 8'hxx;
  endfunction

  function automatic logic beatLastAt(input int i);
    if (i < beatLast.size()) return beatLast[i];
    return 1'bx;
  endfunction

  function automatic logic [7:0] lastIdAt(input int i);
    if (i < lastIds.size()) return lastIds[i];
    return 8'hxx;
  endfunction

  task automatic clearBeats();
    beatData.delete();
    beatLast.delete();
    lastIds.delete();
  endtask

  // One read phase of five cycles, then the falling edge with the bus still held.
  task automatic sendPhase(input bit second, input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (second) read2 = 1'b1;
      else        read1 = 1'b1;
      pix_in1 = a;
      pix_in2 = b;
    end
    @(posedge clk); #1;
    read1 = 1'b0;
    read2 = 1'b0;
    @(posedge clk); #1;
    pix_in1 = 8'h00;
    pix_in2 = 8'h00;
  endtask

  // A complete frame: read1 phase carries px0/px1, read2 phase carries px2/px3.
  task automatic applyStimulus(input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] p3);
    sendPhase(1'b0, p0, p1);
    sendPhase(1'b1, p2, p3);
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    clearBeats();
  endtask

  // Main directed sequence.
  initial begin
    reset       = 1'b1;
    read1       = 1'b0;
    read2       = 1'b0;
    pix_in1     = '0;
    pix_in2     = '0;
    clear_flags = 1'b0;
    out_ready   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      frames[k].id = 8'(k);
      for (int j = 0; j < 4; j++) frames[k].px[j] = 8'((k + 1) * 16 + j);
    end

    // Reset values while reset is held.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_last", 32'(out_last), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_seq", 32'(seq_error), 32'd0);
    checkOutput("rst_drop", 32'(drop_count), 32'd0);
    reset = 1'b0;

    // Single frame streamed with the consumer always ready.
    out_ready = 1'b1;
    applyStimulus(8'h11, 8'h22, 8'h33, 8'h44);
    @(negedge clk);
    checkOutput("sf_first_valid", 32'(out_valid), 32'd1);
    checkOutput("sf_first_data", 32'(out_data), 32'h11);
    repeat (4) @(negedge clk);
    checkOutput("sf_count", 32'(beatData.size()), 32'd4);
    checkOutput("sf_b0", 32'(beatAt(0)), 32'h11);
    checkOutput("sf_b1", 32'(beatAt(1)), 32'h22);
    checkOutput("sf_b2", 32'(beatAt(2)), 32'h33);
    checkOutput("sf_b3", 32'(beatAt(3)), 32'h44);
    checkOutput("sf_last0", 32'(beatLastAt(0)), 32'd0);
    checkOutput("sf_last2", 32'(beatLastAt(2)), 32'd0);
    checkOutput("sf_last3", 32'(beatLastAt(3)), 32'd1);
    checkOutput("sf_id", 32'(lastIdAt(0)), 32'd0);
    checkOutput("sf_level", 32'(fifo_level), 32'd0);
    checkOutput("sf_valid_off", 32'(out_valid), 32'd0);

    // Backpressure: data must hold while stalled, no skips or repeats.
    @(posedge clk); #1;
    out_ready = 1'b0;
    clearBeats();
    applyStimulus(8'h55, 8'h66, 8'h77, 8'h88);
    @(negedge clk);
    checkOutput("bp_level", 32'(fifo_level), 32'd1);
    checkOutput("bp_hold0", 32'(out_data), 32'h55);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      out_ready = patReady[i];
      @(negedge clk);
      checkOutput($sformatf("bp_data%0d", i), 32'(out_data), 32'(patData[i]));
      checkOutput($sformatf("bp_last%0d", i), 32'(out_last), 32'(patLast[i]));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp_count", 32'(beatData.size()), 32'd4);
    checkOutput("bp_b1", 32'(beatAt(1)), 32'h66);
    checkOutput("bp_b2", 32'(beatAt(2)), 32'h77);
    checkOutput("bp_b3", 32'(beatAt(3)), 32'h88);
    checkOutput("bp_id", 32'(lastIdAt(0)), 32'd1);
    checkOutput("bp_level_end", 32'(fifo_level), 32'd0);

    // Overflow: five frames into a four-deep queue with no consumer.
    doReset();
    for (int k = 0; k < 5; k++)
      applyStimulus(frames[k].px[0], frames[k].px[1], frames[k].px[2], frames[k].px[3]);
    @(negedge clk);
    checkOutput("ov_level", 32'(fifo_level), 32'd4);
    checkOutput("ov_flag", 32'(overflow), 32'd1);
    checkOutput("ov_drop", 32'(drop_count), 32'd1);
    checkOutput("ov_head_id", 32'(out_frame_id), 32'd0);
    checkOutput("ov_head_data", 32'(out_data), 32'(frames[0].px[0]));

    // Full queue: frame 5 completes on the same edge the head frame pops.
    sendPhase(1'b0, frames[5].px[0], frames[5].px[1]);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      read2   = 1'b1;
      pix_in1 = frames[5].px[2];
      pix_in2 = frames[5].px[3];
      if (i == 2) out_ready = 1'b1;
    end
    @(posedge clk); #1;
    read2 = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    pix_in1   = 8'h00;
    pix_in2   = 8'h00;
    @(negedge clk);
    checkOutput("fp_level", 32'(fifo_level), 32'd4);
    checkOutput("fp_drop", 32'(drop_count), 32'd1);
    checkOutput("fp_beats", 32'(beatData.size()), 32'd4);
    checkOutput("fp_popped_id", 32'(lastIdAt(0)), 32'd0);
    checkOutput("fp_head_id", 32'(out_frame_id), 32'd1);
    checkOutput("fp_head_data", 32'(out_data), 32'(frames[1].px[0]));

    // Drain the rest: IDs 1,2,3 then 5 (ID 4 was dropped).
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (18) @(negedge clk);
    checkOutput("dr_beats", 32'(beatData.size()), 32'd20);
    checkOutput("dr_id1", 32'(lastIdAt(1)), 32'd1);
    checkOutput("dr_id2", 32'(lastIdAt(2)), 32'd2);
    checkOutput("dr_id3", 32'(lastIdAt(3)), 32'd3);
    checkOutput("dr_id5", 32'(lastIdAt(4)), 32'd5);
    checkOutput("dr_f5_first", 32'(beatAt(16)), 32'(frames[5].px[0]));
    checkOutput("dr_f5_last", 32'(beatAt(19)), 32'(frames[5].px[3]));
    checkOutput("dr_level", 32'(fifo_level), 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Sequence error: read2 phase with no read1 before it.
    clearBeats();
    sendPhase(1'b1, 8'hEE, 8'hEF);
    @(negedge clk);
    checkOutput("se_flag", 32'(seq_error), 32'd1);
    checkOutput("se_level", 32'(fifo_level), 32'd0);
    checkOutput("se_ovf_kept", 32'(overflow), 32'd1);
    @(posedge clk); #1;
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
    @(negedge clk);
    checkOutput("cl_seq", 32'(seq_error), 32'd0);
    checkOutput("cl_ovf", 32'(overflow), 32'd0);
    checkOutput("cl_drop", 32'(drop_count), 32'd0);

    // Both phases ending together count as a read1 end plus an error.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      read1   = 1'b1;
      read2   = 1'b1;
      pix_in1 = 8'hD0;
      pix_in2 = 8'hD1;
    end
    @(posedge clk); #1;
    read1 = 1'b0;
    read2 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("both_seq", 32'(seq_error), 32'd1);
    checkOutput("both_level", 32'(fifo_level), 32'd0);
    sendPhase(1'b1, 8'hD2, 8'hD3);
    @(negedge clk);
    checkOutput("both_push_level", 32'(fifo_level), 32'd1);
    checkOutput("both_px0", 32'(out_data), 32'hD0);
    checkOutput("both_id", 32'(out_frame_id), 32'd6);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("both_b3", 32'(beatAt(3)), 32'hD3);

    // Async reset after two beats of a frame in flight.
    sendPhase(1'b1, 8'hEA, 8'hEB);
    clearBeats();
    applyStimulus(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("ar_valid", 32'(out_valid), 32'd0);
    checkOutput("ar_last", 32'(out_last), 32'd0);
    checkOutput("ar_level", 32'(fifo_level), 32'd0);
    checkOutput("ar_id", 32'(out_frame_id), 32'd0);
    checkOutput("ar_seq", 32'(seq_error), 32'd0);
    checkOutput("ar_beats", 32'(beatData.size()), 32'd2);
    checkOutput("ar_no_last", 32'(lastIds.size()), 32'd0);
    #4;
    reset = 1'b0;
    applyStimulus(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    repeat (6) @(negedge clk);
    checkOutput("ar_next_frames", 32'(lastIds.size()), 32'd1);
    checkOutput("ar_next_id", 32'(lastIdAt(0)), 32'd0);
    checkOutput("ar_next_b0", 32'(beatAt(2)), 32'hB0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pixel_frame_buffer.md
Name: pixel_frame_buffer

Overview:
- Downstream of the pixel top / readout stage.
- Captures the two 8-bit readout registers at the end of each read1 and read2 phase and assembles the 4 pixels of a 2x2 frame.
- Completed frames are queued in a small frame FIFO.
- Queued frames are streamed out one pixel per beat over a valid/ready interface, with a frame-last marker and frame sequence ID, toward the host/serializer.

Parameters:
- DATA_W, 8, pixel width.
- FIFO_DEPTH, 4, frames held; power of 2, >=2.
- CNT_W, 8, width of frame ID and drop counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- read1  in  1  read phase 1 strobe from pixel FSM (multi-cycle level).
- read2  in  1  read phase 2 strobe from pixel FSM (multi-cycle level).
- pix_in1  in  DATA_W  readout register 1 (registered bus sample).
- pix_in2  in  DATA_W  readout register 2.
- clear_flags  in  1  sync pulse; clears overflow, seq_error, drop_count.
- out_data  out  DATA_W  streamed pixel.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  high on pixel 3 of a frame.
- out_frame_id  out  CNT_W  sequence ID of frame being streamed.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames queued, including the one streaming.
- overflow  out  1  sticky; a frame was dropped.
- seq_error  out  1  sticky; read2 phase ended without a preceding read1.
- drop_count  out  CNT_W  dropped frames, saturating.

Behaviour:
- Reset (async, active-high): all outputs 0, FSM = WAIT_R1, FIFO empty, frame ID counter 0, edge registers 0.
- Phase-end detect: read1_q/read2_q hold the previous-cycle strobes.
  - end1 = read1_q & ~read1; end2 = read2_q & ~read2.
  - In the end cycle, pix_in1/pix_in2 still hold the last read-phase sample and are captured then.
- Assembly FSM:
  - WAIT_R1, on end1: px0<=pix_in1, px1<=pix_in2, go to WAIT_R2.
  - WAIT_R1, on end2: set seq_error, discard, stay in WAIT_R1.
  - WAIT_R2, on end2: px2<=pix_in1, px3<=pix_in2, push {px0..px3, id} the same cycle, id<=id+1 (wraps), go to WAIT_R1.
  - WAIT_R2, on end1: overwrite px0/px1 (newer frame wins), stay in WAIT_R2, no error.
  - end1 and end2 in the same cycle: treat as end1 only, set seq_error.
- Push rule: the push succeeds if level<FIFO_DEPTH, or if a frame pop occurs in the same cycle.
  - Otherwise the frame is dropped: overflow<=1, drop_count+1 saturating at all-ones.
  - The ID still increments on a drop, so the consumer sees a gap.
- FIFO: circular, pointer wrap at FIFO_DEPTH, one entry = 4*DATA_W + CNT_W bits.
- Output serializer: 2-bit pixel index idx.
  - out_valid = level!=0.
  - out_data = head pixel[idx]; out_frame_id = head id; out_last = (idx==3).
  - Beat accepted when out_valid&out_ready: idx+1. On the idx==3 beat, idx<=0 and the head is popped.
  - out_data/out_valid/out_last stay stable while out_valid&~out_ready.
- Latency: the first pixel is valid the cycle after the end2 push (registered level/pointers).
- Level updates: push+pop in the same cycle leaves level unchanged.
- clear_flags: clears sticky flags and drop_count next cycle. If an event sets a flag in the same cycle, the set wins.
- Reset mid-stream: frame in flight and partial frame are lost; no out_last is emitted.

Decomposition:
- Shared package pixel_pkg:
  - frame_t struct (px[4] of DATA_W, id).
  - asm_state_t enum {WAIT_R1, WAIT_R2}.
  - constant PIX_PER_FRAME=4.
- One sub-module: pixel_frame_fifo (parameterised depth/width synchronous FIFO with push, pop, level, full, empty).
- Capture FSM and serializer stay in the top.

Test Plan:
- Single frame:
  - Stimulus: read1 5 cycles with pix_in1/2 = 0x11/0x22 at end; then read2 5 cycles with 0x33/0x44; out_ready=1.
  - Response: out beats 0x11,0x22,0x33,0x44; out_last only on 0x44; out_frame_id=0; level back to 0.
- Backpressure:
  - Stimulus: one frame queued, out_ready toggles 1,0,0,1.
  - Response: out_data holds each pixel while stalled; exactly 4 accepts; no duplicate or skip.
- Overflow:
  - Stimulus: out_ready=0, 5 complete frames.
  - Response: level=4; overflow=1; drop_count=1.
  - Then out_ready=1: IDs streamed are 0,1,2,3; the next frame gets ID 5.
- Full with simultaneous pop:
  - Stimulus: level=4, end2 occurs in the same cycle as the last-pixel accept.
  - Response: no drop; level stays 4.
- Sequence error:
  - Stimulus: read2 phase with no preceding read1.
  - Response: seq_error=1, nothing queued.
  - Then clear_flags pulse: seq_error=0 next cycle.
- Async reset mid-stream:
  - Stimulus: assert reset after 2 pixel beats.
  - Response: out_valid, out_last, level, ID, flags all 0 immediately; the next frame after reset has ID 0.
